// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned CNT_W    = $clog2(MD_WIDTH);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: a shift-add multiply step or a restoring divide step.
module muldiv_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   acc_i,
    input  logic [DATA_WIDTH-1:0]     opnd,
    output logic [2*DATA_WIDTH-1:0]   acc_o
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        sum     = {1'b0, acc_i[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, opnd};
        shifted = acc_i[2*DATA_WIDTH-1:DATA_WIDTH-1];
        diff    = shifted[DATA_WIDTH-1:0] - opnd;
        acc_o   = acc_i;
        if (is_div) begin
            if (shifted >= {1'b0, opnd})
                acc_o = {diff, acc_i[DATA_WIDTH-2:0], 1'b1};
            else
                acc_o = {shifted[DATA_WIDTH-1:0], acc_i[DATA_WIDTH-2:0], 1'b0};
        end else if (acc_i[0]) begin
            acc_o = {sum, acc_i[DATA_WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready handshake on both sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = MD_WIDTH,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    MulDivResult,
    output logic                     busy
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);

    muldiv_state_e             state, state_nx;
    muldiv_op_e                op_q;
    logic [DATA_WIDTH-1:0]     a_q, b_q;
    logic [2*DATA_WIDTH-1:0]   acc, acc_step;
    logic                      neg;
    logic [CW-1:0]             cnt;

    logic                      is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg;
    logic [DATA_WIDTH-1:0]     a_abs, b_abs;
    logic                      special;
    logic [DATA_WIDTH-1:0]     special_val;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic [DATA_WIDTH-1:0]     fix_res;

    always_comb begin
        is_div = 1'b0;
        is_rem = 1'b0;
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        unique case (op_q)
            OP_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_MULHSU: a_sgn = 1'b1;
            OP_DIV:    begin is_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_DIVU:   is_div = 1'b1;
            OP_REM:    begin is_div = 1'b1; is_rem = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
            default:   ;
        endcase
        a_neg = a_sgn & a_q[DATA_WIDTH-1];
        b_neg = b_sgn & b_q[DATA_WIDTH-1];
        a_abs = a_neg ? -a_q : a_q;
        b_abs = b_neg ? -b_q : b_q;

        special     = 1'b0;
        special_val = '0;
        if (is_div && b_q == '0) begin
            special     = 1'b1;
            special_val = is_rem ? a_q : '1;
        end else if (is_div && a_sgn && a_q == {1'b1, {(DATA_WIDTH-1){1'b0}}} && b_q == '1) begin
            special     = 1'b1;
            special_val = is_rem ? '0 : a_q;
        end

        prod    = neg ? -acc : acc;
        fix_res = '0;
        unique case (op_q)
            OP_MUL:                      fix_res = prod[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:             fix_res = neg ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
            OP_REM, OP_REMU:             fix_res = neg ? -acc[2*DATA_WIDTH-1:DATA_WIDTH]
                                                       : acc[2*DATA_WIDTH-1:DATA_WIDTH];
            default:                     ;
        endcase
    end

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .is_div (is_div),
        .acc_i  (acc),
        .opnd   (b_q),
        .acc_o  (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Special divide results pass through FIX with a zero sign flag so the
    // result register has a single write point; this gives the 2-cycle latency.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = PREP;
            end
            PREP:    state_nx = special ? FIX : CALC;
            CALC:    if (cnt == CW'(DATA_WIDTH-1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_MUL;
            a_q          <= '0;
            b_q          <= '0;
            acc          <= '0;
            neg          <= 1'b0;
            cnt          <= '0;
            MulDivResult <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid && !flush) begin
                    op_q <= muldiv_op_e'(Operation[2:0]);
                    a_q  <= SrcA;
                    b_q  <= SrcB;
                end
                PREP: begin
                    cnt <= '0;
                    if (special) begin
                        acc <= {special_val, special_val};
                        neg <= 1'b0;
                    end else if (is_div) begin
                        acc <= {{DATA_WIDTH{1'b0}}, a_abs};
                        b_q <= b_abs;
                        neg <= is_rem ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        acc <= {{DATA_WIDTH{1'b0}}, b_abs};
                        b_q <= a_abs;
                        neg <= a_neg ^ b_neg;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FIX:     MulDivResult <= fix_res;
                default: ;
            endcase
        end
    end

endmodule
